apb_requester: RTL and testbench

- APB requester (initiator) that turns a simple valid/ready request/response channel from a core or crossbar into APB transfers.
- Drives one APB completer port, e.g. a GPIO, UART or SPI completer.
- Only one transfer is outstanding at a time.
- A programmable watchdog aborts transfers whose completer never asserts PREADY, so a hung peripheral cannot deadlock the bus.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_req_timer.sv | 28 ++
 rtl/apb_requester.sv | 154 +++++++++++++++
 tb/tb_apb_requester.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its watchdog.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   // Bit positions within PPROT.
   localparam int unsigned PPROT_PRIV   = 0;
   localparam int unsigned PPROT_NONSEC = 1;
   localparam int unsigned PPROT_INSTR  = 2;

   function automatic int unsigned strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_req_timer.sv
// Watchdog counter for the ACCESS phase; flags the last allowed wait cycle.
module apb_req_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // Saturates at all-ones so a long stall can never wrap back to LAST.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && (count_q != '1)) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/apb_requester.sv
// Single-outstanding APB initiator bridging a valid/ready request/response channel,
// with a watchdog that aborts transfers whose completer never raises PREADY.
module apb_requester
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_write,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [2:0]          req_prot,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                resp_timeout,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic                out_psel,
   output logic                out_penable,
   output logic [2:0]          out_pprot,
   output logic                out_pwrite,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   input  logic                out_pready,
   input  logic [DATA_W-1:0]   out_prdata,
   input  logic                out_pslverr
);

   localparam int unsigned STRB_W = strb_w(DATA_W);

   apb_state_e state_q, state_d;

   logic              req_ready_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic [2:0]        prot_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              tmo_q;

   logic capture, complete, abort;
   logic timer_clear, timer_en, expired;
   logic psel, penable, rvalid;

   apb_req_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      psel        = 1'b0;
      penable     = 1'b0;
      rvalid      = 1'b0;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      capture     = 1'b0;
      complete    = 1'b0;
      abort       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               capture = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            psel        = 1'b1;
            timer_clear = 1'b1;
            state_d     = ACCESS;
         end
         ACCESS: begin
            psel     = 1'b1;
            penable  = 1'b1;
            timer_en = 1'b1;
            // A late PREADY on the abort cycle still wins.
            if (out_pready) begin
               complete = 1'b1;
               state_d  = RESP;
            end else if (expired) begin
               abort   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rvalid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         strb_q      <= '0;
         prot_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= (state_d == IDLE);
         if (capture) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            strb_q  <= req_write ? req_wstrb : '0;
            prot_q  <= req_prot;
         end
         if (complete) begin
            rdata_q <= write_q ? '0 : out_prdata;
            err_q   <= out_pslverr;
            tmo_q   <= 1'b0;
         end else if (abort) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
         end
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = rvalid;
   assign resp_rdata   = rdata_q;
   assign resp_err     = err_q;
   assign resp_timeout = tmo_q;
   assign out_psel     = psel;
   assign out_penable  = penable;
   assign out_paddr    = addr_q;
   assign out_pwrite   = write_q;
   assign out_pwdata   = wdata_q;
   assign out_pstrb    = strb_q;
   assign out_pprot    = prot_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized bench for apb_requester against a transfer-level reference model.
module tb_apb_requester;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr;
   logic          req_write;
   logic [DW-1:0] req_wdata;
   logic [3:0]    req_wstrb;
   logic [2:0]    req_prot;
   logic          resp_valid, resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          resp_err, resp_timeout;
   logic [AW-1:0] out_paddr;
   logic          out_psel, out_penable, out_pwrite;
   logic [2:0]    out_pprot;
   logic [DW-1:0] out_pwdata;
   logic [3:0]    out_pstrb;
   logic          out_pready;
   logic [DW-1:0] out_prdata;
   logic          out_pslverr;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   apb_requester #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_write    (req_write),
      .req_wdata    (req_wdata),
      .req_wstrb    (req_wstrb),
      .req_prot     (req_prot),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .resp_timeout (resp_timeout),
      .out_paddr    (out_paddr),
      .out_psel     (out_psel),
      .out_penable  (out_penable),
      .out_pprot    (out_pprot),
      .out_pwrite   (out_pwrite),
      .out_pwdata   (out_pwdata),
      .out_pstrb    (out_pstrb),
      .out_pready   (out_pready),
      .out_prdata   (out_prdata),
      .out_pslverr  (out_pslverr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble_req();
      req_addr  = $urandom;
      req_write = 1'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      req_prot  = 3'($urandom);
   endtask

   // waits = completer wait states before PREADY; waits >= TO means it never readies in time.
   task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic slverr, input logic [31:0] rdata_in, input int hold);
      logic        exp_to;
      int          n_access;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_strb;
      exp_to    = (waits >= int'(TO));
      n_access  = exp_to ? int'(TO) : waits + 1;
      exp_rdata = (exp_to || wr) ? 32'h0 : rdata_in;
      exp_err   = exp_to || slverr;
      exp_strb  = wr ? strb : 4'h0;

      @(negedge clock);
      chk("idle_req_ready", 32'(req_ready), 32'(1));
      chk("idle_psel", 32'(out_psel), 32'(0));
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      req_wdata = wdata;
      req_wstrb = strb;
      req_prot  = prot;

      @(negedge clock);
      req_valid = 1'b0;
      scramble_req();
      chk("setup_psel", 32'(out_psel), 32'(1));
      chk("setup_penable", 32'(out_penable), 32'(0));
      chk("setup_paddr", out_paddr, addr);
      chk("setup_pwrite", 32'(out_pwrite), 32'(wr));
      chk("setup_pstrb", 32'(out_pstrb), 32'(exp_strb));
      chk("setup_pprot", 32'(out_pprot), 32'(prot));
      if (wr) chk("setup_pwdata", out_pwdata, wdata);
      chk("setup_req_ready", 32'(req_ready), 32'(0));
      out_pready  = 1'b1;
      out_pslverr = 1'b1;
      out_prdata  = $urandom;

      for (int k = 0; k < n_access; k++) begin
         @(negedge clock);
         chk("access_psel", 32'(out_psel), 32'(1));
         chk("access_penable", 32'(out_penable), 32'(1));
         chk("access_paddr", out_paddr, addr);
         chk("access_pstrb", 32'(out_pstrb), 32'(exp_strb));
         out_pready  = (k == waits);
         out_prdata  = (k == waits) ? rdata_in : $urandom;
         out_pslverr = (k == waits) ? slverr : 1'($urandom);
      end

      @(negedge clock);
      out_pready  = 1'($urandom);
      out_pslverr = 1'($urandom);
      out_prdata  = $urandom;
      chk("resp_valid", 32'(resp_valid), 32'(1));
      chk("resp_psel", 32'(out_psel), 32'(0));
      chk("resp_penable", 32'(out_penable), 32'(0));
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      chk("resp_timeout", 32'(resp_timeout), 32'(exp_to));
      chk("resp_req_ready", 32'(req_ready), 32'(0));

      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         scramble_req();
         @(negedge clock);
         chk("hold_valid", 32'(resp_valid), 32'(1));
         chk("hold_rdata", resp_rdata, exp_rdata);
         chk("hold_err", 32'(resp_err), 32'(exp_err));
         chk("hold_timeout", 32'(resp_timeout), 32'(exp_to));
         chk("hold_req_ready", 32'(req_ready), 32'(0));
         chk("hold_psel", 32'(out_psel), 32'(0));
      end

      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      out_pready = 1'b0;
      chk("post_resp_valid", 32'(resp_valid), 32'(0));
      chk("post_req_ready", 32'(req_ready), 32'(1));
      chk("post_psel", 32'(out_psel), 32'(0));
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_write   = 1'b0;
      req_wdata   = '0;
      req_wstrb   = '0;
      req_prot    = '0;
      resp_ready  = 1'b0;
      out_pready  = 1'b0;
      out_prdata  = '0;
      out_pslverr = 1'b0;

      repeat (3) @(negedge clock);
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_psel", 32'(out_psel), 32'(0));
      chk("rst_penable", 32'(out_penable), 32'(0));
      chk("rst_resp_valid", 32'(resp_valid), 32'(0));
      chk("rst_paddr", out_paddr, 32'(0));
      chk("rst_pwdata", out_pwdata, 32'(0));
      chk("rst_pstrb", 32'(out_pstrb), 32'(0));
      chk("rst_rdata", resp_rdata, 32'(0));
      chk("rst_err", 32'({resp_err, resp_timeout}), 32'(0));
      reset = 1'b0;

      // Zero-wait write, 3-wait read, PSLVERR read.
      do_xfer(32'h1000_2000, 1'b1, 32'hA5A5_0F0F, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
      do_xfer(32'h1000_2004, 1'b0, 32'h1234_5678, 4'h3, 3'd2, 3, 1'b0, 32'h0000_BEEF, 0);
      do_xfer(32'h1000_2008, 1'b0, 32'h0, 4'h0, 3'd1, 1, 1'b1, 32'hCAFE_F00D, 0);
      // Watchdog: never ready, then ready on the last permitted cycle.
      do_xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 20, 1'b0, 32'hDEAD_0001, 0);
      do_xfer(32'h2000_0004, 1'b1, 32'h0BAD_CAFE, 4'h5, 3'd7, 20, 1'b1, 32'h0, 1);
      do_xfer(32'h2000_0008, 1'b0, 32'h0, 4'h0, 3'd4, int'(TO) - 1, 1'b0, 32'h0000_5A5A, 0);
      // Response back-pressure for 10 cycles.
      do_xfer(32'h3000_0010, 1'b0, 32'h0, 4'h0, 3'd3, 2, 1'b0, 32'h7777_8888, 10);

      // Reset in the middle of ACCESS wait states.
      @(negedge clock);
      req_valid = 1'b1;
      req_addr  = 32'h4000_0000;
      req_write = 1'b0;
      @(negedge clock);
      req_valid  = 1'b0;
      out_pready = 1'b0;
      repeat (2) @(negedge clock);
      chk("mid_penable", 32'(out_penable), 32'(1));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mrst_psel", 32'(out_psel), 32'(0));
      chk("mrst_penable", 32'(out_penable), 32'(0));
      chk("mrst_resp_valid", 32'(resp_valid), 32'(0));
      chk("mrst_req_ready", 32'(req_ready), 32'(0));
      @(negedge clock);
      chk("mrst_req_ready_after", 32'(req_ready), 32'(1));
      chk("mrst_resp_valid_after", 32'(resp_valid), 32'(0));

      // Randomized transfers against the model.
      for (int i = 0; i < 40; i++) begin
         do_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(0, 6)), 1'($urandom), $urandom,
                 int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
